// File: rtl/prewish_mentor_if.sv
// Student-port bundle between prewish_mentor and prewish_blinky, plus the mentor's board-side controls.
// Latency: none, wires only; no backpressure, because the student port has no ACK.
interface prewish_mentor_if;
    logic       STB_O;
    logic [7:0] DAT_O;
    logic [1:0] o_index;
    logic       o_busy;
    logic       i_next;
    logic       i_run;

    modport master (
        output STB_O,
        output DAT_O,
        output o_index,
        output o_busy,
        input  i_next,
        input  i_run
    );

    modport slave (
        input  STB_O,
        input  DAT_O,
        input  o_index,
        input  o_busy,
        output i_next,
        output i_run
    );
endinterface

// File: rtl/prewish_mentor.sv
// Wishbone-subset initiator: strobes one of four blink masks into the student, then dwells until advanced.
// Latency: outputs registered, 1 cycle from decision to STB_O; no backpressure (student never ACKs).
module prewish_mentor #(
    parameter int         STB_LEN    = 2,
    parameter int         DWELL_BITS = 22,
    parameter logic [7:0] PAT0       = 8'hA5,
    parameter logic [7:0] PAT1       = 8'hF0,
    parameter logic [7:0] PAT2       = 8'h81,
    parameter logic [7:0] PAT3       = 8'hFF
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    prewish_mentor_if.master  bus
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    localparam logic [3:0]            STB_LAST   = 4'(STB_LEN - 1);
    localparam logic [DWELL_BITS-1:0] DWELL_LAST = {DWELL_BITS{1'b1}};

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            stb_cnt;
    logic [3:0]            stb_cnt_nxt;
    logic [DWELL_BITS-1:0] dwell_cnt;
    logic [DWELL_BITS-1:0] dwell_cnt_nxt;
    logic                  pending;
    logic                  pending_nxt;
    logic                  stb_nxt;
    logic [7:0]            dat_nxt;
    logic [1:0]            index_nxt;
    logic                  busy_nxt;
    logic                  start_load;
    logic [1:0]            load_idx;

    function automatic logic [7:0] pat_of(input logic [1:0] idx);
        case (idx)
            2'd0:    pat_of = PAT0;
            2'd1:    pat_of = PAT1;
            2'd2:    pat_of = PAT2;
            default: pat_of = PAT3;
        endcase
    endfunction

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state       <= ST_START;
            stb_cnt     <= '0;
            dwell_cnt   <= '0;
            pending     <= 1'b0;
            bus.STB_O   <= 1'b0;
            bus.DAT_O   <= 8'h00;
            bus.o_index <= 2'd0;
            bus.o_busy  <= 1'b0;
        end else begin
            state       <= state_nxt;
            stb_cnt     <= stb_cnt_nxt;
            dwell_cnt   <= dwell_cnt_nxt;
            pending     <= pending_nxt;
            bus.STB_O   <= stb_nxt;
            bus.DAT_O   <= dat_nxt;
            bus.o_index <= index_nxt;
            bus.o_busy  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        stb_cnt_nxt   = stb_cnt;
        dwell_cnt_nxt = dwell_cnt;
        pending_nxt   = pending;
        stb_nxt       = bus.STB_O;
        dat_nxt       = bus.DAT_O;
        index_nxt     = bus.o_index;
        busy_nxt      = bus.o_busy;
        start_load    = 1'b0;
        load_idx      = bus.o_index;

        case (state)
            ST_START: begin
                pending_nxt = pending | bus.i_next;
                start_load  = 1'b1;
                load_idx    = 2'd0;
            end
            ST_LOAD: begin
                // A request arriving mid-strobe is remembered, one deep, for the first dwell cycle.
                pending_nxt = pending | bus.i_next;
                if (stb_cnt == STB_LAST) begin
                    state_nxt     = ST_DWELL;
                    dwell_cnt_nxt = '0;
                    stb_nxt       = 1'b0;
                    dat_nxt       = 8'h00;
                    busy_nxt      = 1'b0;
                end else begin
                    stb_cnt_nxt = stb_cnt + 4'd1;
                end
            end
            ST_DWELL: begin
                // Request and terminal count in the same cycle merge into a single advance.
                if (bus.i_next || pending || (bus.i_run && dwell_cnt == DWELL_LAST)) begin
                    pending_nxt = 1'b0;
                    start_load  = 1'b1;
                    load_idx    = bus.o_index + 2'd1;
                end else if (bus.i_run) begin
                    dwell_cnt_nxt = dwell_cnt + DWELL_BITS'(1);
                end else begin
                    dwell_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt = ST_START;
            end
        endcase

        if (start_load) begin
            state_nxt   = ST_LOAD;
            stb_cnt_nxt = 4'd0;
            stb_nxt     = 1'b1;
            dat_nxt     = pat_of(load_idx);
            index_nxt   = load_idx;
            busy_nxt    = 1'b1;
        end
    end

endmodule

// File: tb/tb_prewish_mentor.sv
// Directed bench for prewish_mentor with STB_LEN=2, DWELL_BITS=3 (10-cycle auto period).
module tb_prewish_mentor;

    logic CLK_I;
    logic RST_I;
    int   errors;
    int   checks;

    prewish_mentor_if bus ();

    prewish_mentor #(
        .STB_LEN    (2),
        .DWELL_BITS (3)
    ) dut (
        .CLK_I (CLK_I),
        .RST_I (RST_I),
        .bus   (bus)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    // Leaves the DUT in DWELL after the first load of PAT0 (three edges after release).
    task automatic do_reset();
        RST_I = 1'b0;
        #2;
        RST_I = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        int stb_seen;
        RST_I      = 1'b0;
        bus.i_next = 1'b0;
        bus.i_run  = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.STB_O, bus.DAT_O, bus.o_index, bus.o_busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: stb=%b dat=%h idx=%0d busy=%b, expected all zero",
                     bus.STB_O, bus.DAT_O, bus.o_index, bus.o_busy);
        end
        RST_I = 1'b1;
        tick();
        checks++;
        if (bus.STB_O !== 1'b1 || bus.DAT_O !== 8'hA5 || bus.o_index !== 2'd0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL first_load_c1: stb=%b dat=%h idx=%0d busy=%b, expected 1 a5 0 1",
                     bus.STB_O, bus.DAT_O, bus.o_index, bus.o_busy);
        end
        tick();
        checks++;
        if (bus.STB_O !== 1'b1 || bus.DAT_O !== 8'hA5) begin
            errors++;
            $display("FAIL first_load_c2: stb=%b dat=%h, expected 1 a5", bus.STB_O, bus.DAT_O);
        end
        tick();
        checks++;
        if (bus.STB_O !== 1'b0 || bus.DAT_O !== 8'h00 || bus.o_busy !== 1'b0 || bus.o_index !== 2'd0) begin
            errors++;
            $display("FAIL first_dwell: stb=%b dat=%h busy=%b idx=%0d, expected 0 00 0 0",
                     bus.STB_O, bus.DAT_O, bus.o_busy, bus.o_index);
        end
        stb_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.STB_O !== 1'b0 || bus.DAT_O !== 8'h00) stb_seen++;
        end
        checks++;
        if (stb_seen !== 0) begin
            errors++;
            $display("FAIL idle_dwell: %0d active cycles with run=0, expected 0", stb_seen);
        end
    endtask

    task automatic test_auto_advance();
        int          rise_tick [5] = '{8, 18, 28, 38, 48};
        logic [7:0]  rise_dat  [5] = '{8'hF0, 8'h81, 8'hFF, 8'hA5, 8'hF0};
        logic [1:0]  rise_idx  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int          got_tick  [8];
        logic [7:0]  got_dat   [8];
        logic [1:0]  got_idx   [8];
        int          nrise;
        int          nhigh;
        logic        prev_stb;
        nrise    = 0;
        nhigh    = 0;
        prev_stb = 1'b0;
        bus.i_run = 1'b1;
        for (int t = 1; t <= 50; t++) begin
            tick();
            if (bus.STB_O === 1'b1) nhigh++;
            if (bus.STB_O === 1'b1 && prev_stb === 1'b0 && nrise < 8) begin
                got_tick[nrise] = t;
                got_dat[nrise]  = bus.DAT_O;
                got_idx[nrise]  = bus.o_index;
                nrise++;
            end
            prev_stb = bus.STB_O;
        end
        bus.i_run = 1'b0;
        checks++;
        if (nrise !== 5) begin
            errors++;
            $display("FAIL auto_load_count: %0d loads, expected 5", nrise);
        end
        checks++;
        if (nhigh !== 10) begin
            errors++;
            $display("FAIL auto_strobe_cycles: %0d strobe cycles, expected 10", nhigh);
        end
        for (int k = 0; k < 5; k++) begin
            if (k < nrise) begin
                checks++;
                if (got_tick[k] !== rise_tick[k] || got_dat[k] !== rise_dat[k] || got_idx[k] !== rise_idx[k]) begin
                    errors++;
                    $display("FAIL auto_load_%0d: cycle=%0d dat=%h idx=%0d, expected cycle=%0d dat=%h idx=%0d",
                             k, got_tick[k], got_dat[k], got_idx[k], rise_tick[k], rise_dat[k], rise_idx[k]);
                end
            end
        end
    endtask

    task automatic test_next_in_dwell();
        int extra;
        bus.i_run = 1'b0;
        do_reset();
        tick();
        tick();
        bus.i_next = 1'b1;
        tick();
        bus.i_next = 1'b0;
        checks++;
        if (bus.STB_O !== 1'b1 || bus.DAT_O !== 8'hF0 || bus.o_index !== 2'd1 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL next_in_dwell: stb=%b dat=%h idx=%0d busy=%b, expected 1 f0 1 1",
                     bus.STB_O, bus.DAT_O, bus.o_index, bus.o_busy);
        end
        tick();
        tick();
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.STB_O !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0 || bus.o_index !== 2'd1) begin
            errors++;
            $display("FAIL next_single_step: %0d extra strobe cycles idx=%0d, expected 0 and idx 1",
                     extra, bus.o_index);
        end
    endtask

    task automatic test_pending();
        int extra;
        bus.i_run  = 1'b0;
        RST_I      = 1'b0;
        #2;
        RST_I      = 1'b1;
        tick();
        bus.i_next = 1'b1;
        tick();
        tick();
        bus.i_next = 1'b0;
        checks++;
        if (bus.STB_O !== 1'b0 || bus.o_index !== 2'd0) begin
            errors++;
            $display("FAIL pending_first_dwell: stb=%b idx=%0d, expected 0 0", bus.STB_O, bus.o_index);
        end
        tick();
        checks++;
        if (bus.STB_O !== 1'b1 || bus.DAT_O !== 8'hF0 || bus.o_index !== 2'd1) begin
            errors++;
            $display("FAIL pending_advance: stb=%b dat=%h idx=%0d, expected 1 f0 1",
                     bus.STB_O, bus.DAT_O, bus.o_index);
        end
        tick();
        tick();
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.STB_O !== 1'b0) extra++;
        end
        checks++;
        if (extra !== 0 || bus.o_index !== 2'd1) begin
            errors++;
            $display("FAIL pending_one_deep: %0d extra strobe cycles idx=%0d, expected 0 and idx 1",
                     extra, bus.o_index);
        end
    endtask

    task automatic test_next_at_expiry();
        bus.i_run = 1'b1;
        do_reset();
        for (int i = 0; i < 7; i++) tick();
        bus.i_next = 1'b1;
        tick();
        bus.i_next = 1'b0;
        checks++;
        if (bus.STB_O !== 1'b1 || bus.DAT_O !== 8'hF0 || bus.o_index !== 2'd1) begin
            errors++;
            $display("FAIL collide_advance: stb=%b dat=%h idx=%0d, expected 1 f0 1",
                     bus.STB_O, bus.DAT_O, bus.o_index);
        end
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (bus.STB_O !== 1'b1 || bus.DAT_O !== 8'h81 || bus.o_index !== 2'd2) begin
            errors++;
            $display("FAIL collide_next_period: stb=%b dat=%h idx=%0d, expected 1 81 2",
                     bus.STB_O, bus.DAT_O, bus.o_index);
        end
        bus.i_run = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.i_run = 1'b0;
        do_reset();
        bus.i_next = 1'b1;
        tick();
        bus.i_next = 1'b0;
        checks++;
        if (bus.STB_O !== 1'b1 || bus.o_index !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset_load: stb=%b idx=%0d, expected 1 1", bus.STB_O, bus.o_index);
        end
        #2;
        RST_I = 1'b0;
        #1;
        checks++;
        if ({bus.STB_O, bus.DAT_O, bus.o_index, bus.o_busy} !== 12'h000) begin
            errors++;
            $display("FAIL async_reset: stb=%b dat=%h idx=%0d busy=%b, expected all zero",
                     bus.STB_O, bus.DAT_O, bus.o_index, bus.o_busy);
        end
        tick();
        RST_I = 1'b1;
        tick();
        checks++;
        if (bus.STB_O !== 1'b1 || bus.DAT_O !== 8'hA5 || bus.o_index !== 2'd0) begin
            errors++;
            $display("FAIL restart_load: stb=%b dat=%h idx=%0d, expected 1 a5 0",
                     bus.STB_O, bus.DAT_O, bus.o_index);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_auto_advance();
        test_next_in_dwell();
        test_pending();
        test_next_at_expiry();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
